entity_scene_writer: RTL and testbench
======================================

// Module: entity_scene_writer
// PURPOSE
//  Producer side of the frame buffer controller's entity interface. Game logic sends slot
//  update commands over a valid/ready handshake into a shadow bank. On commit, the shadow
//  bank is copied into the active bank at the next vertical-blank boundary, so descriptors
//  never change mid-frame. The active bank drives entity_1..entity_9 in the renderer's encoding.
// PARAMETERS
//  V_VISIBLE   480  counter_V value of the first blanking line; its arrival is the frame boundary
//  NUM_SLOTS   9    number of entity slots; slot 0 -> entity_1 ... slot 8 -> entity_9_Flip
//  V_TILE_MAX  11   largest legal tile Y coordinate
// PORTS
//  clk_in          in   1   system clock
//  reset           in   1   asynchronous, active-low reset
//  cmd_valid       in   1   command present
//  cmd_ready       out  1   command accepted when cmd_valid & cmd_ready at a rising edge
//  cmd_op          in   2   00 write slot, 01 clear slot, 10 clear all, 11 commit request
//  cmd_slot        in   4   target slot 0..8 (used by ops 00/01)
//  cmd_data        in   18  {id[3:0], orient[1:0], X[3:0], Y[3:0], array_len[3:0]}
//  counter_V       in   10  vertical pixel counter, shared with the renderer
//  entity_1..6     out  14  active slots 0..5: {id, orient, X, Y}
//  entity_7_Array  out  18  active slot 6: full 18-bit word including array_len
//  entity_8_Flip   out  14  active slot 7
//  entity_9_Flip   out  14  active slot 8
//  commit_pending  out  1   commit requested and the copy has not yet finished
//  frame_tick      out  1   one-cycle pulse on the frame boundary
//  cmd_err         out  1   one-cycle pulse when an accepted command was rejected as illegal
// BEHAVIOUR
//  - Unused slot word: id = 4'hF, all other bits 0.
//    - 14-bit form: 14'h3C00. 18-bit form: 18'h3C000.
//  - Reset (asynchronous, immediate, including mid-COPY or mid-CLEAR):
//    - Both banks hold the unused word; all entity outputs show it.
//    - cmd_ready=0, commit_pending=0, frame_tick=0, cmd_err=0, state IDLE.
//    - cmd_ready rises on the first clock edge after reset release.
//  - Frame boundary detection:
//    - prev_V is registered every cycle.
//    - boundary = (counter_V == V_VISIBLE) && (prev_V != V_VISIBLE).
//    - frame_tick is asserted the cycle after the boundary is detected.
//  - States: IDLE, PENDING, COPY, CLEAR. cmd_ready = (state == IDLE || state == PENDING).
//  - Op 00 (write slot), single cycle:
//    - shadow[slot] <= cmd_data; slots 0,1,2,3,4,5,7,8 force array_len to 0.
//    - If slot > 8 or Y > V_TILE_MAX: no write, and cmd_err pulses the next cycle.
//  - Op 01 (clear slot): shadow[slot] <= unused word. Same slot check as op 00.
//  - Op 10 (clear all): enter CLEAR with cmd_ready=0.
//    - Writes shadow[k] <= unused word for k = 0..8, one slot per cycle (9 cycles).
//    - Then returns to the previous state (IDLE or PENDING).
//  - Op 11 (commit): in IDLE, go to PENDING and set commit_pending=1. In PENDING: no-op.
//  - PENDING + boundary: go to COPY on the next cycle.
//    - COPY writes active[k] <= shadow[k] for k = 0..8, one slot per cycle.
//    - After k = 8: go to IDLE and clear commit_pending.
//    - Slot k is visible on its output exactly k+2 cycles after the boundary cycle.
//  - A command accepted in the boundary cycle is applied before COPY starts, so it is
//    included in the copy.
//  - A boundary that occurs in CLEAR, COPY or IDLE does not trigger a copy; it only
//    pulses frame_tick. A commit pending across a CLEAR waits for the next boundary.
//  - Shadow writes never touch the active bank. The active bank changes only in COPY.
//  - counter_V held constant or skipping V_VISIBLE: no boundary; commit stays pending.
// TESTING
//  - Reset release: all entity_1..6/8/9 = 14'h3C00 and entity_7_Array = 18'h3C000;
//    cmd_ready=1 one edge after reset release.
//  - Write slot 0 with 18'h05A30, then commit, then counter_V 479->480:
//    - commit_pending=1 until the copy ends.
//    - entity_1 = 14'h05A3 two cycles after the boundary; outputs unchanged before it.
//  - Write slot 6 with array_len 4'h7; write slot 8 with array_len 4'h5; commit; boundary:
//    - entity_7_Array[3:0] = 4'h7.
//    - entity_9_Flip = upper 14 bits of the written word (array_len dropped).
//  - Illegal writes: cmd_slot = 9, and Y = 12 on slot 2:
//    - cmd_err pulses once for each.
//    - The shadow is unchanged; after commit + boundary, entity_3 = 14'h3C00.
//  - Commit, then clear-all issued during PENDING, then boundary during CLEAR:
//    - cmd_ready=0 for 9 cycles; no copy happens.
//    - The next boundary copies all-unused words.
//  - Assert reset during the COPY cycle for k = 4: all outputs are the unused word
//    immediately, and commit_pending = 0.

Source files
------------

// File: rtl/entity_scene_writer.sv
// Entity scene writer: shadow/active descriptor banks with a commit that lands
// on the vertical-blank boundary, so the renderer never sees a mid-frame change.
module entity_scene_writer #(
   parameter int unsigned V_VISIBLE  = 480,
   parameter int unsigned NUM_SLOTS  = 9,
   parameter int unsigned V_TILE_MAX = 11
) (
   input  logic        clk_in,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [3:0]  cmd_slot,
   input  logic [17:0] cmd_data,
   input  logic [9:0]  counter_V,
   output logic [13:0] entity_1,
   output logic [13:0] entity_2,
   output logic [13:0] entity_3,
   output logic [13:0] entity_4,
   output logic [13:0] entity_5,
   output logic [13:0] entity_6,
   output logic [17:0] entity_7_Array,
   output logic [13:0] entity_8_Flip,
   output logic [13:0] entity_9_Flip,
   output logic        commit_pending,
   output logic        frame_tick,
   output logic        cmd_err
);

   localparam logic [17:0] UNUSED    = 18'h3C000;
   localparam logic [3:0]  LAST_SLOT = 4'(NUM_SLOTS - 1);
   localparam logic [3:0]  ARRAY_SLOT = 4'd6;

   typedef enum logic [1:0] {IDLE, PENDING, COPY, CLEAR} state_t;
   typedef enum logic [1:0] {
      OP_WRITE     = 2'b00,
      OP_CLEAR     = 2'b01,
      OP_CLEAR_ALL = 2'b10,
      OP_COMMIT    = 2'b11
   } op_t;

   state_t      state;
   state_t      ret_state;
   logic [3:0]  idx;
   logic [9:0]  prev_v;
   logic [17:0] shadow [NUM_SLOTS];
   logic [17:0] active [NUM_SLOTS];

   logic        boundary;
   logic        accept;
   logic        bad_slot;
   logic        bad_y;
   logic [17:0] wdata;

   assign boundary = (counter_V == 10'(V_VISIBLE)) && (prev_v != 10'(V_VISIBLE));
   assign accept   = cmd_valid && cmd_ready;
   assign bad_slot = cmd_slot > LAST_SLOT;
   assign bad_y    = cmd_data[7:4] > 4'(V_TILE_MAX);
   assign wdata    = (cmd_slot == ARRAY_SLOT) ? cmd_data : {cmd_data[17:4], 4'b0000};

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         ret_state      <= IDLE;
         idx            <= '0;
         prev_v         <= '0;
         cmd_ready      <= 1'b0;
         commit_pending <= 1'b0;
         frame_tick     <= 1'b0;
         cmd_err        <= 1'b0;
         for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
            shadow[k] <= UNUSED;
            active[k] <= UNUSED;
         end
      end else begin
         prev_v     <= counter_V;
         frame_tick <= boundary;
         cmd_err    <= 1'b0;
         case (state)
            IDLE, PENDING: begin
               cmd_ready <= 1'b1;
               if (accept) begin
                  case (op_t'(cmd_op))
                     OP_WRITE: begin
                        if (bad_slot || bad_y) cmd_err <= 1'b1;
                        else                   shadow[cmd_slot] <= wdata;
                     end
                     OP_CLEAR: begin
                        if (bad_slot) cmd_err <= 1'b1;
                        else          shadow[cmd_slot] <= UNUSED;
                     end
                     OP_CLEAR_ALL: begin
                        ret_state <= state;
                        state     <= CLEAR;
                        idx       <= '0;
                        cmd_ready <= 1'b0;
                     end
                     OP_COMMIT: begin
                        state          <= PENDING;
                        commit_pending <= 1'b1;
                     end
                     default: ;
                  endcase
               end
               // A clear-all accepted on the boundary wins; the commit waits for the next frame.
               if (state == PENDING && boundary && !(accept && op_t'(cmd_op) == OP_CLEAR_ALL)) begin
                  state     <= COPY;
                  idx       <= '0;
                  cmd_ready <= 1'b0;
               end
            end
            CLEAR: begin
               shadow[idx] <= UNUSED;
               if (idx == LAST_SLOT) begin
                  state     <= ret_state;
                  cmd_ready <= 1'b1;
               end else begin
                  idx <= idx + 4'd1;
               end
            end
            COPY: begin
               active[idx] <= shadow[idx];
               if (idx == LAST_SLOT) begin
                  state          <= IDLE;
                  commit_pending <= 1'b0;
                  cmd_ready      <= 1'b1;
               end else begin
                  idx <= idx + 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign entity_1       = active[0][17:4];
   assign entity_2       = active[1][17:4];
   assign entity_3       = active[2][17:4];
   assign entity_4       = active[3][17:4];
   assign entity_5       = active[4][17:4];
   assign entity_6       = active[5][17:4];
   assign entity_7_Array = active[6];
   assign entity_8_Flip  = active[7][17:4];
   assign entity_9_Flip  = active[8][17:4];

endmodule

// File: tb/tb_entity_scene_writer.sv
// Scoreboard bench for entity_scene_writer: directed commands push expected
// output events (slot change or cmd_err pulse, with cycle); a monitor pops them.
module tb_entity_scene_writer;

   logic        clk_in = 1'b0;
   logic        reset = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = '0;
   logic [3:0]  cmd_slot = '0;
   logic [17:0] cmd_data = '0;
   logic [9:0]  counter_V = '0;
   logic [13:0] entity_1, entity_2, entity_3, entity_4, entity_5, entity_6;
   logic [17:0] entity_7_Array;
   logic [13:0] entity_8_Flip, entity_9_Flip;
   logic        commit_pending, frame_tick, cmd_err;

   entity_scene_writer #(.V_VISIBLE(480), .NUM_SLOTS(9), .V_TILE_MAX(11)) dut (
      .clk_in(clk_in), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_slot(cmd_slot), .cmd_data(cmd_data), .counter_V(counter_V),
      .entity_1(entity_1), .entity_2(entity_2), .entity_3(entity_3), .entity_4(entity_4),
      .entity_5(entity_5), .entity_6(entity_6), .entity_7_Array(entity_7_Array),
      .entity_8_Flip(entity_8_Flip), .entity_9_Flip(entity_9_Flip),
      .commit_pending(commit_pending), .frame_tick(frame_tick), .cmd_err(cmd_err)
   );

   always #5 clk_in = ~clk_in;

   // kind 0 = cmd_err pulse, kind k+1 = output of slot k changed to val
   typedef struct {
      int          kind;
      logic [17:0] val;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   int          n_tests = 0;
   int          n_fail = 0;
   int          cyc = 0;
   bit          mon_en = 1'b0;
   logic [17:0] last_out [9];
   logic [17:0] cur_out [9];

   function automatic logic [17:0] get_out(int k);
      case (k)
         0: return {4'b0, entity_1};
         1: return {4'b0, entity_2};
         2: return {4'b0, entity_3};
         3: return {4'b0, entity_4};
         4: return {4'b0, entity_5};
         5: return {4'b0, entity_6};
         6: return entity_7_Array;
         7: return {4'b0, entity_8_Flip};
         default: return {4'b0, entity_9_Flip};
      endcase
   endfunction

   initial forever begin
      @(posedge clk_in);
      cyc++;
   end

   // Monitor: every output change or cmd_err pulse must match the head of the scoreboard.
   initial begin
      for (int k = 0; k < 9; k++) last_out[k] = 18'h0;
      forever begin
         @(negedge clk_in);
         for (int k = 0; k < 9; k++) cur_out[k] = get_out(k);
         if (mon_en) begin
            for (int e = 0; e < 10; e++) begin
               bit          hit;
               logic [17:0] v;
               hit = (e == 0) ? (cmd_err === 1'b1) : (cur_out[e-1] !== last_out[e-1]);
               v   = (e == 0) ? 18'h0 : cur_out[e-1];
               if (hit) begin
                  n_tests++;
                  if (sb.size() == 0) begin
                     n_fail++;
                     $display("FAIL sb_unexpected: kind=%0d val=%h cyc=%0d, none expected", e, v, cyc);
                  end else begin
                     exp_t x;
                     x = sb.pop_front();
                     if (x.kind != e || x.val !== v || x.cyc != cyc) begin
                        n_fail++;
                        $display("FAIL sb_event: got kind=%0d val=%h cyc=%0d, expected kind=%0d val=%h cyc=%0d",
                                 e, v, cyc, x.kind, x.val, x.cyc);
                     end
                  end
               end
            end
         end
         for (int k = 0; k < 9; k++) last_out[k] = cur_out[k];
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   task automatic chk(string name, logic [17:0] act, logic [17:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic push(int kind, logic [17:0] val, int c);
      exp_t x;
      x.kind = kind;
      x.val  = val;
      x.cyc  = c;
      sb.push_back(x);
   endtask

   task automatic step(int k);
      repeat (k) @(posedge clk_in);
      #1;
   endtask

   task automatic wait_ready();
      int w;
      w = 0;
      while (cmd_ready !== 1'b1 && w < 50) begin
         step(1);
         w++;
      end
      if (cmd_ready !== 1'b1) begin
         n_tests++;
         n_fail++;
         $display("FAIL ready_timeout: cmd_ready=%b, expected 1 within 50 cycles", cmd_ready);
      end
   endtask

   task automatic send(logic [1:0] op, logic [3:0] slot, logic [17:0] data, bit expect_err);
      wait_ready();
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_slot  = slot;
      cmd_data  = data;
      if (expect_err) push(0, 18'h0, cyc + 1);
      step(1);
      cmd_valid = 1'b0;
   endtask

   task automatic pre_frame(output int n);
      counter_V = 10'd479;
      step(1);
      n = cyc;
   endtask

   task automatic fire();
      counter_V = 10'd480;
      step(1);
      chk("frame_tick", {17'b0, frame_tick}, 18'h1);
   endtask

   // Called one cycle after the boundary: copy of slot 8 completes 10 cycles after it.
   task automatic wait_copy();
      step(8);
      chk("pending_in_copy", {17'b0, commit_pending}, 18'h1);
      chk("ready_in_copy", {17'b0, cmd_ready}, 18'h0);
      step(1);
      chk("pending_after_copy", {17'b0, commit_pending}, 18'h0);
      chk("ready_after_copy", {17'b0, cmd_ready}, 18'h1);
   endtask

   logic [17:0] wvals [9];
   logic [17:0] evals [9];

   initial begin
      int n;

      // Reset state
      step(3);
      for (int k = 0; k < 9; k++)
         chk($sformatf("reset_out%0d", k), get_out(k), (k == 6) ? 18'h3C000 : 18'h03C00);
      chk("reset_ready", {17'b0, cmd_ready}, 18'h0);
      chk("reset_pending", {17'b0, commit_pending}, 18'h0);
      chk("reset_err", {17'b0, cmd_err}, 18'h0);
      reset = 1'b1;
      #1;
      chk("ready_before_edge", {17'b0, cmd_ready}, 18'h0);
      mon_en = 1'b1;
      step(1);
      chk("ready_first_edge", {17'b0, cmd_ready}, 18'h1);

      // Single slot write + commit
      send(2'b00, 4'd0, 18'h05A30, 1'b0);
      chk("shadow_not_active", {4'b0, entity_1}, 18'h03C00);
      send(2'b11, 4'd0, 18'h0, 1'b0);
      chk("commit_pending_set", {17'b0, commit_pending}, 18'h1);
      pre_frame(n);
      push(1, 18'h005A3, n + 2);
      fire();
      wait_copy();
      chk("entity_1", {4'b0, entity_1}, 18'h005A3);

      // Array slot keeps array_len, flip slot drops it
      send(2'b00, 4'd6, 18'h0B457, 1'b0);
      send(2'b00, 4'd8, 18'h25AB5, 1'b0);
      send(2'b11, 4'd0, 18'h0, 1'b0);
      pre_frame(n);
      push(7, 18'h0B457, n + 8);
      push(9, 18'h025AB, n + 10);
      fire();
      wait_copy();
      chk("entity_7_len", {14'b0, entity_7_Array[3:0]}, 18'h7);
      chk("entity_9_flip", {4'b0, entity_9_Flip}, 18'h025AB);

      // Illegal commands, and write-then-clear of a slot
      send(2'b00, 4'd9, 18'h05A30, 1'b1);
      send(2'b00, 4'd2, 18'h042C0, 1'b1);
      send(2'b01, 4'd15, 18'h0, 1'b1);
      send(2'b00, 4'd1, 18'h2A5A0, 1'b0);
      send(2'b01, 4'd1, 18'h0, 1'b0);
      send(2'b11, 4'd0, 18'h0, 1'b0);
      pre_frame(n);
      fire();
      wait_copy();
      chk("entity_3_unused", {4'b0, entity_3}, 18'h03C00);
      chk("entity_2_unused", {4'b0, entity_2}, 18'h03C00);

      // Commit, clear-all during PENDING, boundary during CLEAR
      send(2'b11, 4'd0, 18'h0, 1'b0);
      wait_ready();
      cmd_valid = 1'b1;
      cmd_op    = 2'b10;
      step(1);
      cmd_valid = 1'b0;
      for (int i = 0; i < 9; i++) begin
         chk($sformatf("clear_ready_%0d", i), {17'b0, cmd_ready}, 18'h0);
         if (i == 0) counter_V = 10'd479;
         if (i == 1) counter_V = 10'd480;
         if (i == 2) chk("clear_frame_tick", {17'b0, frame_tick}, 18'h1);
         step(1);
      end
      chk("clear_ready_back", {17'b0, cmd_ready}, 18'h1);
      step(5);
      chk("clear_still_pending", {17'b0, commit_pending}, 18'h1);
      pre_frame(n);
      push(1, 18'h03C00, n + 2);
      push(7, 18'h3C000, n + 8);
      push(9, 18'h03C00, n + 10);
      fire();
      wait_copy();

      // Skipped V_VISIBLE, then reset in the middle of a copy
      wvals = '{18'h01000, 18'h05110, 18'h09220, 18'h0D330, 18'h11440,
                18'h15550, 18'h19660, 18'h1D770, 18'h21880};
      evals = '{18'h00100, 18'h00511, 18'h00922, 18'h00D33, 18'h01144,
                18'h01555, 18'h19660, 18'h01D77, 18'h02188};
      for (int k = 0; k < 9; k++) send(2'b00, 4'(k), wvals[k], 1'b0);
      send(2'b11, 4'd0, 18'h0, 1'b0);
      counter_V = 10'd479;
      step(1);
      counter_V = 10'd481;
      step(1);
      chk("skip_no_tick", {17'b0, frame_tick}, 18'h0);
      step(3);
      chk("skip_pending", {17'b0, commit_pending}, 18'h1);
      pre_frame(n);
      for (int k = 0; k < 4; k++) push(k + 1, evals[k], n + 2 + k);
      fire();
      step(4);
      @(negedge clk_in);
      #1;
      mon_en = 1'b0;
      reset  = 1'b0;
      #1;
      for (int k = 0; k < 9; k++)
         chk($sformatf("midcopy_reset_out%0d", k), get_out(k), (k == 6) ? 18'h3C000 : 18'h03C00);
      chk("midcopy_reset_pending", {17'b0, commit_pending}, 18'h0);
      chk("midcopy_reset_ready", {17'b0, cmd_ready}, 18'h0);
      step(2);
      reset = 1'b1;
      step(1);
      mon_en = 1'b1;
      chk("rerelease_ready", {17'b0, cmd_ready}, 18'h1);
      step(3);
      chk("scoreboard_drained", 18'(sb.size()), 18'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
